// File: rtl/product_accumulator.sv
// Sums a counted burst of unsigned products into a wide accumulator.
// Carry-out is tracked as a sticky overflow flag alongside the sum.
module product_accumulator #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf,
    output logic              busy
);

    if (ACC_W < PROD_W) begin : g_width_check
        $error("ACC_W must be >= PROD_W");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_nx;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   cnt_nx;
    logic               ovf_q;
    logic               ovf_nx;
    logic [ACC_W:0]     sum;

    // Extra top bit captures the carry out of the accumulator.
    assign sum = {1'b0, acc} + (ACC_W+1)'(prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            ovf_q <= ovf_nx;
        end
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        ovf_nx   = ovf_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    acc_nx   = '0;
                    ovf_nx   = 1'b0;
                    cnt_nx   = len;
                    state_nx = (len == '0) ? OUT : ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    acc_nx = sum[ACC_W-1:0];
                    ovf_nx = ovf_q | sum[ACC_W];
                    cnt_nx = cnt - 1'b1;
                    if (cnt == LEN_W'(1)) begin
                        state_nx = OUT;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // All outputs decode from registered state only.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign acc_out   = acc;
    assign ovf       = ovf_q;

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter: PROD_W, default 32, product width; matches the 16x16 array multiplier output.
REQ-002 Parameter: ACC_W, default 40, accumulator width; SHALL be >= PROD_W.
REQ-003 Parameter: LEN_W, default 8, width of the beat-count field.
REQ-004 Port: clk  in  1  sole clock; all state on rising edge.
REQ-005 Port: rst  in  1  reset; asynchronous, active-high.
REQ-006 Port: start  in  1  begin a new accumulation; sampled in IDLE only.
REQ-007 Port: len  in  LEN_W  number of products to sum; sampled with start.
REQ-008 Port: in_valid  in  1  prod holds a valid product.
REQ-009 Port: in_ready  out  1  block accepts prod this cycle.
REQ-010 Port: prod  in  PROD_W  unsigned product from the array multiplier.
REQ-011 Port: out_valid  out  1  acc_out and ovf hold a final result.
REQ-012 Port: out_ready  in  1  consumer takes the result.
REQ-013 Port: acc_out  out  ACC_W  accumulated sum, registered.
REQ-014 Port: ovf  out  1  sticky; set if any addition carried out of ACC_W.
REQ-015 Port: busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM SHALL have exactly three states: IDLE, ACC, OUT.
REQ-017 IDLE: in_ready=0, out_valid=0; start=1 with len!=0 -> acc=0, ovf=0, cnt=len, next state ACC.
REQ-018 IDLE: start=1 with len=0 -> acc=0, ovf=0, next state OUT (empty sum).
REQ-019 ACC: in_ready=1 combinationally from state; beat accepted iff in_valid&in_ready.
REQ-020 Accepted beat: acc <= acc + zero-extended prod, mod 2^ACC_W; ovf <= ovf | carry-out; cnt <= cnt-1.
REQ-021 Accepted beat with cnt==1 -> next state OUT; no further beats accepted.
REQ-022 ACC, in_valid=0: acc, cnt and ovf hold; no timeout.
REQ-023 OUT: out_valid=1, in_ready=0; acc_out and ovf stable until handshake.
REQ-024 OUT with out_ready=1 -> next state IDLE; out_valid low the following cycle.
REQ-025 Latency: out_valid rises the cycle after the last beat is accepted.
REQ-026 start SHALL be ignored in ACC and OUT; len is not re-sampled.
REQ-027 out_ready outside OUT SHALL have no effect.
REQ-028 Back-to-back: start in the IDLE cycle after an OUT handshake SHALL be honoured; min 1 idle cycle between jobs.
REQ-029 acc_out SHALL hold the last result in IDLE until the next start clears it.
REQ-030 No combinational path from in_valid/out_ready to any output.

Reset
REQ-031 rst=1 SHALL force IDLE, acc=0, cnt=0, ovf=0, in_ready=0, out_valid=0, busy=0 immediately, without waiting for clk.
REQ-032 Reset mid-ACC or mid-OUT SHALL discard the partial sum; no result is emitted.
REQ-033 First start is honoured on the first rising edge after rst deasserts.

Verification
REQ-034 start, len=3; prods 0x00000006, 0x0000000F, 0xFFFFFFFF, in_valid always high -> out_valid 1 cycle after 3rd beat, acc_out=0x0100000014, ovf=0.
REQ-035 start, len=2; in_valid toggles 1,0,0,1 with prods 5 and 7 -> exactly 2 beats accepted, acc_out=12, out_valid on the cycle after the 4th.
REQ-036 ACC_W=33, len=3, prods 0xFFFFFFFF x3 -> acc_out=0x0FFFFFFFD, ovf=1, held until out_ready.
REQ-037 start with len=0 -> OUT next cycle, acc_out=0, ovf=0; in_ready never asserted.
REQ-038 out_ready held low 10 cycles in OUT, start pulsed during that time -> result stable, start ignored, IDLE after out_ready=1.
REQ-039 rst asserted between clk edges mid-ACC after 2 of 4 beats -> all outputs at reset values before the next edge; a new start, len=1, prod=9 yields acc_out=9.
